// File: rtl/dot_operand_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dot_operand_feeder: streams buffered A/B operand pairs (A0,B0,A1,B1,...) |
// | over a valid/ready bus, then pulses stop. Option: FEEDER_ZERO_SKIP_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dot_operand_feeder #(
  parameter int DW    = 7,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_vec,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          stop
);

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B, FIN} state_e;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] data_q, data_d;
  logic          sel_q, sel_d;
  logic          valid_q, valid_d;

  logic [DW-1:0] buf_a_q [DEPTH];
  logic [DW-1:0] buf_b_q [DEPTH];

  logic          wr_fire;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a_rd, b_rd;

  assign wr_fire = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < LEN_MAX);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_vec) buf_b_q[wr_addr] <= wr_data;
      else        buf_a_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (len > LEN_MAX) ? LEN_MAX : len;
          idx_d   = '0;
          state_d = (len_d != '0) ? EMIT_A : FIN;
        end
      end
      EMIT_A: begin
`ifdef FEEDER_ZERO_SKIP_EN
        // A non-valid cycle in EMIT_A means the current pair was zero-skipped.
        if (!valid_q) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_d == len_q) ? FIN : EMIT_A;
        end else
`endif
        if (valid_q && out_ready) begin
          state_d = EMIT_B;
        end
      end
      EMIT_B: begin
        if (out_ready) begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_d == len_q) ? FIN : EMIT_A;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are fetched for the next state, with the same-cycle write forwarded.
  assign rd_addr = idx_d[AW-1:0];

  always_comb begin
    a_rd = buf_a_q[rd_addr];
    b_rd = buf_b_q[rd_addr];
    if (wr_fire && (wr_addr == rd_addr)) begin
      if (wr_vec) b_rd = wr_data;
      else        a_rd = wr_data;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    sel_d   = 1'b0;
    data_d  = '0;
    if (state_d == EMIT_A) begin
      valid_d = 1'b1;
      data_d  = a_rd;
`ifdef FEEDER_ZERO_SKIP_EN
      if ((a_rd == '0) || (b_rd == '0)) begin
        valid_d = 1'b0;
        data_d  = '0;
      end
`endif
    end else if (state_d == EMIT_B) begin
      valid_d = 1'b1;
      sel_d   = 1'b1;
      data_d  = b_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign stop      = (state_q == FIN);

endmodule
`default_nettype wire

// File: tb/tb_dot_operand_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dot_operand_feeder: directed self-checking bench for the feeder.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dot_operand_feeder;
  localparam int DW = 7;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en = 1'b0;
  logic          wr_vec = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic          out_valid;
  logic          busy;
  logic          stop;

  dot_operand_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_vec(wr_vec),
    .wr_addr(wr_addr), .wr_data(wr_data), .len(len), .start(start),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .stop(stop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int got_d[$];
  int got_s[$];
  int got_c[$];
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic v, input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_vec = v; wr_addr = a[AW-1:0]; wr_data = d[DW-1:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Cycle c = 1 is the cycle right after the edge that samples start.
  task automatic run(input int ln, input int mode, input bit mid_wr, input bit ws,
                     input int wa, input int wd, output int stop_cyc);
    logic          pv;
    logic [DW-1:0] pd;
    logic          ps;
    got_d.delete(); got_s.delete(); got_c.delete();
    stop_cyc = -1;
    pv = 1'b0; pd = '0; ps = 1'b0;
    @(negedge clk);
    len = ln[AW:0]; start = 1'b1; out_ready = 1'b1;
    wr_en = ws; wr_vec = 1'b1; wr_addr = wa[AW-1:0]; wr_data = wd[DW-1:0];
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 100 && stop_cyc < 0; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
      wr_en = mid_wr && (c == 2); wr_vec = 1'b0; wr_addr = '0; wr_data = 7'd9;
      if (c == 1) check("busy_in_stream", busy, 1);
      if (pv) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
        check("hold_sel", out_sel, ps);
      end
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_s.push_back(int'(out_sel));
        got_c.push_back(c);
      end
      pv = out_valid && !out_ready; pd = out_data; ps = out_sel;
      if (stop) stop_cyc = c;
      @(negedge clk);
    end
    wr_en = 1'b0; out_ready = 1'b0;
    if (stop_cyc < 0) check("stop_timeout", 0, 1);
    check("idle_busy", busy, 0);
    check("idle_stop", stop, 0);
  endtask

  task automatic cmp_ops(input string tag);
    check({tag, "_count"}, got_d.size(), exp_q.size());
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      check({tag, "_data"}, got_d[i], exp_q[i]);
      check({tag, "_sel"}, got_s[i], i % 2);
    end
  endtask

  initial begin
    int sc;
    int seen;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_data", out_data, 0);
    check("rst_sel", out_sel, 0);
    check("rst_stop", stop, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    wr(0, 0, 3); wr(0, 1, 5); wr(0, 2, 7);
    wr(1, 0, 2); wr(1, 1, 4); wr(1, 2, 6);
    exp_q = '{3, 2, 5, 4, 7, 6};

    run(3, 0, 0, 0, 0, 0, sc);
    cmp_ops("basic");
    check("basic_stop_cyc", sc, 7);
    for (int i = 0; i < got_c.size(); i++) check("basic_cycle", got_c[i], i + 1);

    run(3, 1, 0, 0, 0, 0, sc);
    cmp_ops("bp");
    check("bp_stop_cyc", sc, 17);

    run(0, 0, 0, 0, 0, 0, sc);
    check("len0_count", got_d.size(), 0);
    check("len0_stop_cyc", sc, 1);

    for (int i = 0; i < 8; i++) begin
      wr(0, i, i + 1);
      wr(1, i, 20 + i);
    end
    // Write of B[7]=50 lands in the same cycle as start and must be streamed.
    exp_q = '{1, 20, 2, 21, 3, 22, 4, 23, 5, 24, 6, 25, 7, 26, 8, 50};
    run(12, 0, 0, 1, 7, 50, sc);
    cmp_ops("clamp");
    check("clamp_stop_cyc", sc, 17);

    exp_q = '{1, 20, 2, 21};
    run(2, 0, 1, 0, 0, 0, sc);
    cmp_ops("busywr1");
    exp_q = '{1, 20};
    run(1, 0, 0, 0, 0, 0, sc);
    cmp_ops("busywr2");

    @(negedge clk);
    len = 4'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_pre_valid", out_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_stop", stop, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stop || out_valid) seen++;
    end
    check("abort_no_stop", seen, 0);
    out_ready = 1'b0;

    wr(0, 0, 4); wr(0, 1, 0); wr(0, 2, 1);
    wr(1, 0, 3); wr(1, 1, 2); wr(1, 2, 0);
`ifdef FEEDER_ZERO_SKIP_EN
    exp_q = '{4, 3};
    run(3, 0, 0, 0, 0, 0, sc);
    cmp_ops("zero");
    check("zero_stop_cyc", sc, 5);
`else
    exp_q = '{4, 3, 0, 2, 1, 0};
    run(3, 0, 0, 0, 0, 0, sc);
    cmp_ops("zero");
    check("zero_stop_cyc", sc, 7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_operand_feeder.md
# dot_operand_feeder

Upstream operand sequencer for the dot-product datapath/control pair. It holds two operand vectors, A and B, in small local buffers that a host loads over a write port. On `start` it streams the pairs as A0, B0, A1, B1, … onto a single 7-bit operand bus using a valid/ready handshake. After the last pair is transferred it issues a one-cycle `stop` pulse, which ends accumulation in the control path.

## Interface
- `DW`, default 7: operand width; matches the datapath's `data_in` bus.
- `DEPTH`, default 8: elements per vector buffer.
- `AW`, default 3: buffer address width; must satisfy 2^AW ≥ DEPTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for a buffer entry.
- `wr_vec`  in  1  target buffer: 0 = A, 1 = B.
- `wr_addr`  in  AW  entry index.
- `wr_data`  in  DW  entry value.
- `len`  in  AW+1  number of pairs to stream; sampled on `start`.
- `start`  in  1  begins a stream; acted on only in IDLE.
- `out_data`  out  DW  current operand.
- `out_sel`  out  1  0 = A operand, 1 = B operand.
- `out_valid`  out  1  `out_data` and `out_sel` are valid.
- `out_ready`  in  1  consumer accepts the operand when `out_valid` is high.
- `busy`  out  1  high in every state except IDLE.
- `stop`  out  1  one-cycle pulse marking end of stream.

## Operation
- FSM states: IDLE, EMIT_A, EMIT_B, FIN.
- IDLE:
  - Accepts writes: `wr_en` writes `wr_data` into buffer[`wr_vec`][`wr_addr`].
  - Writes with `wr_addr` ≥ DEPTH are dropped.
  - On `start`: capture `len_q` = min(`len`, DEPTH) and clear `idx`.
  - Next state is EMIT_A if `len_q` > 0, else FIN.
- EMIT_A:
  - Drives `out_data` = A[`idx`], `out_sel` = 0, `out_valid` = 1.
  - On transfer (`out_valid` & `out_ready`), go to EMIT_B.
- EMIT_B:
  - Drives `out_data` = B[`idx`], `out_sel` = 1, `out_valid` = 1.
  - On transfer: `idx` ← `idx` + 1; go to FIN if `idx` + 1 == `len_q`, else EMIT_A.
- FIN: `stop` = 1 and `out_valid` = 0 for exactly one cycle; then IDLE.
- Writes while `busy` is high are ignored. The buffers are never modified mid-stream.
- `start` while `busy` is high is ignored.
- `idx` and `len_q` are unsigned, AW+1 bits wide. `idx` never exceeds `len_q`, so no wrap-around occurs.
- Buffers are not cleared by reset; their contents are undefined until written.

## Timing
- Reset values: `out_data` = 0, `out_sel` = 0, `out_valid` = 0, `busy` = 0, `stop` = 0. FSM = IDLE, `idx` = 0, `len_q` = 0.
- Reset asserted mid-stream aborts immediately: outputs go to their reset values and no `stop` pulse is issued.
- Stream latency:
  - `start` sampled at edge N → `out_valid` high from cycle N+1 with A0.
  - With `out_ready` held high, one operand transfers per cycle.
  - For `len` = L, `stop` is high in cycle N+1+2L. IDLE (`busy` low) resumes in cycle N+2+2L.
- Backpressure: while `out_valid` & !`out_ready`, `out_data` and `out_sel` hold stable. `out_valid` never drops without a transfer.
- `len` = 0: `stop` is high in cycle N+1 with no operands emitted.
- A write and a `start` in the same IDLE cycle: the write completes, and its value is visible to the stream.
- Outputs are registered; no combinational path from `out_ready` to `out_data`.

## Configuration
- `FEEDER_ZERO_SKIP_EN` defined:
  - In EMIT_A, if A[`idx`] == 0 or B[`idx`] == 0, the pair is skipped.
  - `out_valid` stays 0 for that cycle, `idx` increments, and the FSM re-evaluates EMIT_A, or goes to FIN if `idx` + 1 == `len_q`.
  - Each skipped pair costs one cycle instead of two transfers. If every pair is zero, only the `stop` pulse appears.
- Undefined: every pair is emitted regardless of value; there is no zero check.

## Test plan
- Reset with `rst_n` = 0: all outputs 0 and `busy` = 0 while reset is held and after release.
- Load A = {3,5,7}, B = {2,4,6}; `len` = 3; `out_ready` = 1:
  - Stream 3,2,5,4,7,6 with `out_sel` 0,1,0,1,0,1 in consecutive cycles.
  - `stop` pulses in cycle 7 after `start`.
- Same load, `out_ready` toggled 1,0,0,1,…: each operand is held stable while not ready, and the sequence is unchanged.
- `len` = 0: `stop` is pulsed in cycle 1 with no valid operands. `len` = 12 with DEPTH = 8: exactly 8 pairs are emitted.
- Write A[0] = 9 during an active stream, then run again: the second stream still emits the old A[0]. Assert `rst_n` low mid-stream: `out_valid` drops immediately and no `stop` occurs.
- With `FEEDER_ZERO_SKIP_EN`, A = {4,0,1}, B = {3,2,0}, `len` = 3: emits only 4,3, then pulses `stop`. Without the macro, emits 4,3,0,2,1,0.
